wb_sel_stage: RTL

//  Pipeline register directly upstream of the 8:1 writeback result mux.

---
 rtl/wb_sel_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wb_sel_stage.sv
// rtl/wb_sel_stage.sv - 2-entry skid pipeline register feeding the writeback result mux.
// Optional backpressure counter enabled by defining WB_STALL_CNT_EN.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif

module wb_sel_stage #(
    parameter int DATA_W     = `ARCH_WIDTH,
    parameter int REG_ADDR_W = 5
`ifdef WB_STALL_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_sel,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [DATA_W-1:0]     in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_sel,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wen,
    output logic [DATA_W-1:0]     out_imm
`ifdef WB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    localparam int PW = 3 + REG_ADDR_W + 1 + DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic            in_ready_q, in_ready_d;
    logic [PW-1:0]   in_payload;
    logic            accept;
    logic            deliver;

    assign in_payload = {in_sel, in_rd, in_wen, in_imm};
    assign accept     = in_valid && in_ready_q;
    assign deliver    = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_payload;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    main_d = in_payload;
                end else if (accept) begin
                    skid_d  = in_payload;
                    state_d = FULL;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain of SKID into MAIN can happen
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_sel   = main_q[PW-1 -: 3];
    assign out_rd    = main_q[DATA_W+1 +: REG_ADDR_W];
    assign out_wen   = main_q[DATA_W] && out_valid;
    assign out_imm   = main_q[DATA_W-1:0];

`ifdef WB_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
